// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and FSM encoding for the memory backend
package mem_pkg;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam int DEFAULT_LATENCY = 10;
  localparam int BOOT_ADDR = 'h100;
  localparam logic [31:0] BOOT_WORD = 32'hCAFEBABE;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: word-write RAM with a registered 4-word line read port
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [LINE_BITS-1:0]           line
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BOOT_IDX = (BOOT_ADDR / 4) % DEPTH_WORDS;
  logic [31:0] mem [DEPTH_WORDS] = '{BOOT_IDX: BOOT_WORD, default: 32'h0};
  logic [AW-1:0] base;
  assign base = idx & ~AW'(LINE_WORDS - 1);
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[idx] <= wdata;
      for (int i = 0; i < LINE_WORDS; i++) line[32*i +: 32] <= we ? 32'h0 : mem[base | AW'(i)];
    end
endmodule

// File: rtl/mem_backend.sv
// mem_backend: fixed-latency memory backend serving word writes and 4-word line reads
module mem_backend
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [LINE_BITS-1:0] resp_rdata
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state;
  logic [7:0] cnt;
  logic lat_we;
  logic [AW-1:0] lat_idx;
  logic [31:0] lat_wdata;
  logic accept, go_resp, op_we;
  logic [AW-1:0] op_idx;
  logic [31:0] op_wdata;
  logic [LINE_BITS-1:0] line;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign accept = req_valid && req_ready;
  assign go_resp = LATENCY == 1 ? accept : state == BUSY && cnt == 8'd1;
  assign op_we = state == IDLE ? req_we : lat_we;
  assign op_idx = state == IDLE ? req_addr[AW+1:2] : lat_idx;
  assign op_wdata = state == IDLE ? req_wdata : lat_wdata;
  assign resp_rdata = resp_valid ? line : '0;
  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk(clk),
    .en(go_resp && !reset),
    .we(op_we),
    .idx(op_idx),
    .wdata(op_wdata),
    .line(line)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lat_we <= 1'b0;
      lat_idx <= '0;
      lat_wdata <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
    end else
      case (state)
        IDLE: if (accept) begin
          lat_we <= req_we;
          lat_idx <= req_addr[AW+1:2];
          lat_wdata <= req_wdata;
          cnt <= 8'(LATENCY - 1);
          state <= LATENCY == 1 ? RESP : BUSY;
          req_ready <= 1'b0;
          resp_valid <= LATENCY == 1;
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          state <= cnt == 8'd1 ? RESP : BUSY;
          resp_valid <= cnt == 8'd1;
        end
        default: begin
          state <= IDLE;
          req_ready <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_mem_backend.sv
// tb_mem_backend: table, directed and random checks of mem_backend against a word-array model
module tb_mem_backend;
  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] exp;
  } vec_t;
  logic clk, reset;
  logic req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic req_ready, resp_valid;
  logic [127:0] resp_rdata;
  logic r1_valid;
  logic [31:0] r1_addr;
  logic r1_ready, r1_resp;
  logic [127:0] r1_rdata;
  int errors, checks;
  logic [31:0] model [4096];
  vec_t tbl [8];
  mem_backend #(.LATENCY(10), .DEPTH_WORDS(4096)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );
  mem_backend #(.LATENCY(1), .DEPTH_WORDS(4096)) dut1 (
    .clk(clk), .reset(reset), .req_valid(r1_valid), .req_we(1'b0), .req_addr(r1_addr),
    .req_wdata(32'h0), .req_ready(r1_ready), .resp_valid(r1_resp), .resp_rdata(r1_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [127:0] exp_line(input logic [31:0] a);
    int base = int'(a[13:4]) * 4;
    for (int i = 0; i < 4; i++) exp_line[32*i +: 32] = model[base + i];
  endfunction
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                     output logic [127:0] rd, output int lat);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
    lat = 1;
    while (!resp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    if (!resp_valid) lat = -1;
  endtask
  task automatic run(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [127:0] exp, input string name);
    logic [127:0] rd;
    int lat;
    txn(we, a, d, rd, lat);
    if (we) model[a[13:2]] = d;
    chk({name, " rdata"}, rd, exp);
    chk({name, " latency"}, 128'(lat), 128'(10));
    @(posedge clk); #1;
    chk({name, " after pulse valid/ready/rdata"}, 128'({resp_valid, req_ready, |resp_rdata}), 128'(3'b010));
  endtask
  initial begin
    int acc, pulses, last, bad_gap;
    logic we;
    logic [31:0] a, d;
    errors = 0; checks = 0;
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
    model[32'h100 >> 2] = 32'hCAFEBABE;
    tbl[0] = '{1'b0, 32'h100, 32'h0, {96'h0, 32'hCAFEBABE}};
    tbl[1] = '{1'b1, 32'h104, 32'h9999, 128'h0};
    tbl[2] = '{1'b0, 32'h100, 32'h0, {64'h0, 32'h9999, 32'hCAFEBABE}};
    tbl[3] = '{1'b0, 32'h4100, 32'h0, {64'h0, 32'h9999, 32'hCAFEBABE}};
    tbl[4] = '{1'b0, 32'h103, 32'h0, {64'h0, 32'h9999, 32'hCAFEBABE}};
    tbl[5] = '{1'b1, 32'h30E, 32'hA5A5, 128'h0};
    tbl[6] = '{1'b0, 32'h300, 32'h0, {32'hA5A5, 96'h0}};
    tbl[7] = '{1'b0, 32'h1FC, 32'h0, 128'h0};
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    r1_valid = 1'b0; r1_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset ready/valid", 128'({req_ready, resp_valid}), 128'(2'b10));
    chk("reset rdata", resp_rdata, 128'h0);
    chk("lat1 reset ready", 128'(r1_ready), 128'(1));
    r1_valid = 1'b1; r1_addr = 32'h100;
    @(posedge clk); #1;
    r1_valid = 1'b0;
    chk("lat1 resp/ready", 128'({r1_resp, r1_ready}), 128'(2'b10));
    chk("lat1 rdata", r1_rdata, {96'h0, 32'hCAFEBABE});
    @(posedge clk); #1;
    chk("lat1 after resp/ready", 128'({r1_resp, r1_ready}), 128'(2'b01));
    chk("lat1 after rdata", r1_rdata, 128'h0);
    for (int i = 0; i < 8; i++) run(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("tbl%0d", i));
    acc = 0; pulses = 0; last = -1; bad_gap = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    for (int c = 0; c < 44; c++) begin
      if (req_ready) begin
        if (last >= 0 && c - last != 11) bad_gap++;
        last = c;
        acc++;
      end
      @(posedge clk); #1;
      if (resp_valid) begin
        pulses++;
        chk("hold rdata", resp_rdata, exp_line(32'h100));
      end
    end
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    chk("hold accepts", 128'(acc), 128'(4));
    chk("hold pulses", 128'(pulses), 128'(4));
    chk("hold accept spacing errors", 128'(bad_gap), 128'(0));
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abandon ready after reset", 128'({req_ready, resp_valid}), 128'(2'b10));
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (resp_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("abandon pulses", 128'(pulses), 128'(0));
    run(1'b0, 32'h200, 32'h0, 128'h0, "abandon readback");
    for (int k = 0; k < 24; k++) begin
      we = 1'($urandom);
      a = $urandom & 32'hFFFF_C3FF;
      d = $urandom;
      run(we, a, d, we ? 128'h0 : exp_line(a), $sformatf("rand%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
